// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default framing constants.
// Also intended for the receiver side so both ends agree on the basics.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
    localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// bit period. 'clear' holds the count at zero so a new frame starts on a full bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Bit-period counter: held at zero by clear, otherwise wraps at each bit boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= CNT_ZERO;
        end else if (clear) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Decoded straight off the counter register so it coincides with the bit's final cycle
    assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and serialises them as
// start / 8 data (LSB first) / optional parity / 1-2 stop bits, back to back.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_do,
    output logic       fifo_re,
    output logic       tx,
    output logic       busy
);

    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [2:0] IDX_LAST  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_r;
    logic [7:0]     shift_r;
    logic           parity_r;
    logic [2:0]     idx_r;
    logic           stop_cnt_r;
    logic           tx_r;
    logic           busy_r;

    logic           tick_s;
    logic           frame_end_s;
    logic           pop_s;
    logic           clear_s;

    // The last cycle of the last stop bit is the only in-frame point where a new byte may be taken.
    // The pop is gated by reset so the FIFO is never touched while reset is held.
    assign frame_end_s = (state_r == STOP) && tick_s && (stop_cnt_r == STOP_LAST);
    assign pop_s       = reset && enable && !fifo_empty && ((state_r == IDLE) || frame_end_s);
    assign clear_s     = (state_r == IDLE) || pop_s;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Frame sequencer: loads on a pop, advances one bit per tick, drives tx/busy registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            shift_r    <= 8'h00;
            parity_r   <= 1'b0;
            idx_r      <= 3'd0;
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else if (pop_s) begin
            state_r    <= START;
            shift_r    <= fifo_do;
            parity_r   <= PARITY_ODD;
            idx_r      <= 3'd0;
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                end
                START: begin
                    if (tick_s) begin
                        state_r <= DATA;
                        idx_r   <= 3'd0;
                        tx_r    <= shift_r[0];
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        shift_r  <= {1'b0, shift_r[7:1]};
                        parity_r <= parity_r ^ shift_r[0];
                        idx_r    <= idx_r + 3'd1;
                        if (idx_r == IDX_LAST) begin
                            if (PARITY_EN) begin
                                state_r <= PARITY;
                                tx_r    <= parity_r ^ shift_r[0];
                            end else begin
                                state_r    <= STOP;
                                stop_cnt_r <= 1'b0;
                                tx_r       <= 1'b1;
                            end
                        end else begin
                            tx_r <= shift_r[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick_s) begin
                        state_r    <= STOP;
                        stop_cnt_r <= 1'b0;
                        tx_r       <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (stop_cnt_r == STOP_LAST) begin
                            state_r    <= IDLE;
                            stop_cnt_r <= 1'b0;
                            tx_r       <= 1'b1;
                            busy_r     <= 1'b0;
                        end else begin
                            stop_cnt_r <= stop_cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_re = pop_s;
    assign tx      = tx_r;
    assign busy    = busy_r;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drains the UART TX FIFO and drives the `tx` pin. It sits directly downstream of the peripheral's byte FIFO and reads from it through the FIFO's `re`/`empty`/`do` interface. It frames each byte as 8N1 by default, with optional parity and a second stop bit. Consecutive bytes are sent with no idle gap between frames.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per bit (100 MHz / 115200); must be ≥ 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: with `PARITY_EN`, 0 selects even parity and 1 selects odd.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: allows new frames to start; a frame already in progress always completes.
- `fifo_empty` in 1: the FIFO's `empty` output.
- `fifo_do` in 8: the FIFO's `do` output; the head byte, valid whenever `fifo_empty`=0.
- `fifo_re` out 1: pop strobe to the FIFO's `re`; combinational, one cycle per byte.
- `tx` out 1: serial line; registered; idle level is 1.
- `busy` out 1: registered; 1 from the cycle after a pop until the final stop-bit cycle ends.

## Operation
- States are IDLE, START, DATA, PARITY and STOP.
- Pop condition: `fifo_re` = `enable` & !`fifo_empty` & (state==IDLE, or state==STOP on the last cycle of the last stop bit).
- On a pop edge:
  - `fifo_do` is loaded into an 8-bit shift register.
  - The parity accumulator is set to `PARITY_ODD`.
  - The state moves to START and the baud counter clears.
- START drives `tx`=0 for `CLKS_PER_BIT` cycles, then moves to DATA with the bit index at 0.
- DATA:
  - Drives `tx` = shift[0], sending the LSB first.
  - Each bit lasts `CLKS_PER_BIT` cycles; at the end of a bit the register shifts right, the parity accumulator XORs in the bit just sent, and the index increments.
  - After index 7, the state moves to PARITY if `PARITY_EN`, otherwise to STOP.
- PARITY drives `tx` = accumulator for one bit time, then moves to STOP.
- STOP:
  - Drives `tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles.
  - On the final cycle, it pops (see the pop condition) and goes to START, or else goes to IDLE.
- IDLE drives `tx`=1 and `busy`=0.
- Counters:
  - The baud counter is $clog2(`CLKS_PER_BIT`) bits wide, counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary.
  - The stop-bit counter is 1 bit wide.
  - The bit index is 3 bits wide.
- Boundary conditions:
  - FIFO empty on the final stop cycle: go to IDLE with `tx`=1 and no pop.
  - `enable` falling mid-frame: the frame finishes and no further pop occurs.
  - `enable` rising while the FIFO is non-empty in IDLE: pop in that same cycle.
  - `fifo_re` is never asserted while `fifo_empty`=1, and never more than once per frame.
  - Reset asserted mid-frame: takes effect immediately. `tx`=1, `busy`=0, state is IDLE and all counters are 0. The partially sent byte is lost; the FIFO is not touched.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_re`=0 (while reset is held).
- Latency: a pop at edge N gives `tx`=0 in the cycle after edge N, with no further delay.
- Frame length is (1+8+`PARITY_EN`+`STOP_BITS`)×`CLKS_PER_BIT` cycles, i.e. 10×`CLKS_PER_BIT` for 8N1.
- Back-to-back frames: the next start bit begins in the cycle immediately after the last stop-bit cycle, with no gap.
- FIFO contract: `do` must already be stable when `fifo_re` is sampled; the pop takes effect at the same edge.

## Structure
- Shared package `uart_pkg`: the state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP) and the defaults `UART_DEFAULT_CLKS_PER_BIT`=868 and `UART_DATA_BITS`=8. These are shared with the future `uart_rx`.
- One sub-module: `uart_baud_gen`.
  - Parameter: `CLKS_PER_BIT`.
  - Inputs: `clk`, `reset`, `clear`.
  - Output: a one-cycle `tick` on the last cycle of each bit period.
  - `uart_rx` will reuse it.

## Test plan
All scenarios run with `CLKS_PER_BIT`=4.
- **Reset:** hold `reset`=0 → `tx`=1, `busy`=0, `fifo_re`=0; after release with an empty FIFO, `tx` stays 1 for 100 cycles.
- **Single byte, 8N1:** push 0x55 → one `fifo_re` pulse; `tx` sends 0, then 1,0,1,0,1,0,1,0, then 1, each for 4 cycles; frame is 40 cycles; `busy` high for exactly 40 cycles.
- **Back-to-back:** push 0xA3 and 0x0F → two pops 40 cycles apart; the start bit of 0x0F immediately follows the stop bit of 0xA3; the line equals the concatenation of both frames.
- **Parity and two stop bits:** `PARITY_EN`=1, `PARITY_ODD`=0, `STOP_BITS`=2, byte 0x07 → parity bit 1, two stop bits, frame of 48 cycles. With `PARITY_ODD`=1 the parity bit is 0.
- **Enable control:** deassert `enable` during data bit 3 with 2 bytes queued → the current frame completes, the line then idles, and there is no second pop. Reasserting `enable` gives a pop in the same cycle.
- **Reset mid-frame:** assert `reset` in data bit 5 → `tx`=1 and `busy`=0 asynchronously. After release, the next queued byte is sent intact.
